// File: rtl/fetch_if.sv
// Fetch-side bus bundle: instruction memory port, decode handshake,
// redirect request and fault report.
interface fetch_if;
  logic [63:0] imAddr;
  logic        imReq;
  logic [31:0] imData;
  logic        instValid;
  logic        instReady;
  logic [31:0] inst;
  logic [63:0] instPc;
  logic        redirect;
  logic [63:0] redirectPc;
  logic        fault;
  logic [63:0] faultPc;

  modport master (
    output imAddr, imReq, instValid, inst, instPc, fault, faultPc,
    input  imData, instReady, redirect, redirectPc
  );

  modport slave (
    input  imAddr, imReq, instValid, inst, instPc, fault, faultPc,
    output imData, instReady, redirect, redirectPc
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads IM combinationally and
// buffers {PC, word} pairs in a small FIFO for decode.
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 2,
  parameter int          IM_WORDS = 16
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     en_i,
  fetch_if.master  bus
);

  localparam int          PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CntW    = $clog2(DEPTH + 1);
  localparam logic [63:0] PcLimit = 64'(4 * IM_WORDS);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFault
  } state_e;

  state_e            state_q, state_d;
  logic [63:0]       pc_q, pc_d;
  logic [63:0]       faultPc_q, faultPc_d;
  logic [31:0]       memInst_q [DEPTH];
  logic [63:0]       memPc_q   [DEPTH];
  logic [PtrW-1:0]   rdPtr_q, rdPtr_d;
  logic [PtrW-1:0]   wrPtr_q, wrPtr_d;
  logic [CntW-1:0]   count_q, count_d;

  logic push;
  logic pop;
  logic flush;
  logic full;
  logic pcLegal;

  always_comb begin
    pop     = (count_q != '0) && bus.instReady;
    full    = (count_q == CntW'(DEPTH));
    pcLegal = (pc_q[1:0] == 2'b00) && (pc_q < PcLimit);

    state_d   = state_q;
    pc_d      = pc_q;
    faultPc_d = faultPc_q;
    push      = 1'b0;
    flush     = 1'b0;

    // Redirect outranks everything: flush buffer, reload PC, clear any fault.
    if (bus.redirect) begin
      flush   = 1'b1;
      pc_d    = bus.redirectPc;
      state_d = (state_q == StIdle) ? StIdle : StRun;
    end else begin
      case (state_q)
        StIdle: begin
          if (en_i) state_d = StRun;
        end
        StRun: begin
          if (!pcLegal) begin
            state_d   = StFault;
            faultPc_d = pc_q;
          end else if (!full || pop) begin
            push = 1'b1;
            pc_d = pc_q + 64'd4;
          end
        end
        StFault: begin
          state_d = StFault;
        end
        default: state_d = StIdle;
      endcase
    end

    if (flush) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      rdPtr_d = rdPtr_q + PtrW'(pop);
      wrPtr_d = wrPtr_q + PtrW'(push);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      faultPc_q <= '0;
      rdPtr_q   <= '0;
      wrPtr_q   <= '0;
      count_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        memInst_q[i] <= '0;
        memPc_q[i]   <= '0;
      end
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      faultPc_q <= faultPc_d;
      rdPtr_q   <= rdPtr_d;
      wrPtr_q   <= wrPtr_d;
      count_q   <= count_d;
      if (push) begin
        memInst_q[wrPtr_q] <= bus.imData;
        memPc_q[wrPtr_q]   <= pc_q;
      end
    end
  end

  assign bus.imAddr    = pc_q;
  assign bus.imReq     = push;
  assign bus.instValid = (count_q != '0);
  assign bus.inst      = bus.instValid ? memInst_q[rdPtr_q] : '0;
  assign bus.instPc    = bus.instValid ? memPc_q[rdPtr_q] : '0;
  assign bus.fault     = (state_q == StFault);
  assign bus.faultPc   = faultPc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: streaming, stall, redirect, range and
// alignment faults, mid-stream reset and back-to-back redirects.
module tb_fetch_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic en;
  int   checkCount = 0;
  int   passCount  = 0;

  fetch_if bus ();

  fetch_ctrl #(
    .RESET_PC (64'h0),
    .DEPTH    (2),
    .IM_WORDS (16)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (en),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // IM model: each word encodes the low half of its own address.
  function automatic logic [31:0] expInst(input logic [63:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  assign bus.imData = expInst(bus.imAddr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0;
    bus.instReady = 1'b0; bus.redirect = 1'b0; bus.redirectPc = '0;
    tick();
    @(negedge clk);
    checkCount++; if (bus.instValid !== 1'b0) $display("[TB] FAIL rst_valid: got %b expected 0", bus.instValid); else passCount++;
    checkCount++; if (bus.inst !== 32'h0) $display("[TB] FAIL rst_inst: got %h expected 0", bus.inst); else passCount++;
    checkCount++; if (bus.instPc !== 64'h0) $display("[TB] FAIL rst_instpc: got %h expected 0", bus.instPc); else passCount++;
    checkCount++; if (bus.imReq !== 1'b0) $display("[TB] FAIL rst_imreq: got %b expected 0", bus.imReq); else passCount++;
    checkCount++; if (bus.fault !== 1'b0) $display("[TB] FAIL rst_fault: got %b expected 0", bus.fault); else passCount++;
    checkCount++; if (bus.imAddr !== 64'h0) $display("[TB] FAIL rst_imaddr: got %h expected 0", bus.imAddr); else passCount++;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    en = 1'b1; bus.instReady = 1'b1;
    @(negedge clk);
    checkCount++; if (bus.imReq !== 1'b0) $display("[TB] FAIL seq_idle_req: got %b expected 0", bus.imReq); else passCount++;
    tick();
    en = 1'b0;
    @(negedge clk);
    checkCount++; if (bus.imReq !== 1'b1 || bus.imAddr !== 64'h0) $display("[TB] FAIL seq_first_fetch: got req=%b addr=%h expected req=1 addr=0", bus.imReq, bus.imAddr); else passCount++;
    checkCount++; if (bus.instValid !== 1'b0) $display("[TB] FAIL seq_first_valid: got %b expected 0", bus.instValid); else passCount++;
    tick();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkCount++;
      if (bus.instValid !== 1'b1 || bus.instPc !== 64'(4 * k) || bus.inst !== expInst(64'(4 * k)) || bus.imAddr !== 64'(4 * k + 4))
        $display("[TB] FAIL seq_stream[%0d]: got v=%b pc=%h inst=%h addr=%h expected v=1 pc=%h inst=%h addr=%h", k, bus.instValid, bus.instPc, bus.inst, bus.imAddr, 64'(4 * k), expInst(64'(4 * k)), 64'(4 * k + 4));
      else passCount++;
      tick();
    end
  endtask

  task automatic test_stall();
    bus.instReady = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      checkCount++;
      if (bus.instValid !== 1'b1 || bus.instPc !== 64'h18 || bus.inst !== expInst(64'h18))
        $display("[TB] FAIL stall_head[%0d]: got v=%b pc=%h inst=%h expected v=1 pc=18", s, bus.instValid, bus.instPc, bus.inst);
      else passCount++;
      checkCount++;
      if (bus.imReq !== (s == 0) || (s > 0 && bus.imAddr !== 64'h20))
        $display("[TB] FAIL stall_req[%0d]: got req=%b addr=%h expected req=%b addr=20", s, bus.imReq, bus.imAddr, (s == 0));
      else passCount++;
      tick();
    end
    bus.instReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkCount++;
      if (bus.instPc !== 64'(24 + 4 * k) || bus.imReq !== 1'b1)
        $display("[TB] FAIL stall_resume[%0d]: got pc=%h req=%b expected pc=%h req=1", k, bus.instPc, bus.imReq, 64'(24 + 4 * k));
      else passCount++;
      tick();
    end
  endtask

  task automatic test_redirect();
    bus.redirect = 1'b1; bus.redirectPc = 64'h20;
    @(negedge clk);
    checkCount++; if (bus.instValid !== 1'b1 || bus.instPc !== 64'h24) $display("[TB] FAIL redir_head: got v=%b pc=%h expected v=1 pc=24", bus.instValid, bus.instPc); else passCount++;
    checkCount++; if (bus.imReq !== 1'b0) $display("[TB] FAIL redir_nopush: got %b expected 0", bus.imReq); else passCount++;
    tick();
    bus.redirect = 1'b0;
    @(negedge clk);
    checkCount++; if (bus.instValid !== 1'b0) $display("[TB] FAIL redir_flush: got %b expected 0", bus.instValid); else passCount++;
    checkCount++; if (bus.imReq !== 1'b1 || bus.imAddr !== 64'h20) $display("[TB] FAIL redir_fetch: got req=%b addr=%h expected req=1 addr=20", bus.imReq, bus.imAddr); else passCount++;
    tick();
    @(negedge clk);
    checkCount++; if (bus.instValid !== 1'b1 || bus.instPc !== 64'h20) $display("[TB] FAIL redir_target: got v=%b pc=%h expected v=1 pc=20", bus.instValid, bus.instPc); else passCount++;
    tick();
  endtask

  task automatic test_range_fault();
    for (int h = 'h24; h <= 'h3C; h += 4) begin
      @(negedge clk);
      checkCount++;
      if (bus.instValid !== 1'b1 || bus.instPc !== 64'(h) || bus.imReq !== (h != 'h3C) || bus.fault !== 1'b0)
        $display("[TB] FAIL range_stream[%h]: got v=%b pc=%h req=%b fault=%b expected v=1 pc=%h req=%b fault=0", h, bus.instValid, bus.instPc, bus.imReq, bus.fault, 64'(h), (h != 'h3C));
      else passCount++;
      tick();
    end
    @(negedge clk);
    checkCount++; if (bus.fault !== 1'b1 || bus.faultPc !== 64'h40) $display("[TB] FAIL range_fault: got fault=%b pc=%h expected fault=1 pc=40", bus.fault, bus.faultPc); else passCount++;
    checkCount++; if (bus.instValid !== 1'b0) $display("[TB] FAIL range_novalid: got %b expected 0", bus.instValid); else passCount++;
    tick();
    bus.redirect = 1'b1; bus.redirectPc = 64'h0;
    @(negedge clk);
    checkCount++; if (bus.fault !== 1'b1 || bus.imReq !== 1'b0) $display("[TB] FAIL range_sticky: got fault=%b req=%b expected fault=1 req=0", bus.fault, bus.imReq); else passCount++;
    tick();
    bus.redirect = 1'b0;
    @(negedge clk);
    checkCount++; if (bus.fault !== 1'b0 || bus.imReq !== 1'b1 || bus.imAddr !== 64'h0) $display("[TB] FAIL range_recover: got fault=%b req=%b addr=%h expected fault=0 req=1 addr=0", bus.fault, bus.imReq, bus.imAddr); else passCount++;
    tick();
    @(negedge clk);
    checkCount++; if (bus.instValid !== 1'b1 || bus.instPc !== 64'h0) $display("[TB] FAIL range_resume: got v=%b pc=%h expected v=1 pc=0", bus.instValid, bus.instPc); else passCount++;
    tick();
  endtask

  task automatic test_misaligned();
    bus.redirect = 1'b1; bus.redirectPc = 64'h6;
    @(negedge clk);
    checkCount++; if (bus.instValid !== 1'b1 || bus.instPc !== 64'h4) $display("[TB] FAIL mis_head: got v=%b pc=%h expected v=1 pc=4", bus.instValid, bus.instPc); else passCount++;
    tick();
    bus.redirect = 1'b0;
    @(negedge clk);
    checkCount++; if (bus.imReq !== 1'b0 || bus.instValid !== 1'b0 || bus.fault !== 1'b0 || bus.imAddr !== 64'h6) $display("[TB] FAIL mis_take: got req=%b v=%b fault=%b addr=%h expected req=0 v=0 fault=0 addr=6", bus.imReq, bus.instValid, bus.fault, bus.imAddr); else passCount++;
    tick();
    @(negedge clk);
    checkCount++; if (bus.fault !== 1'b1 || bus.faultPc !== 64'h6 || bus.instValid !== 1'b0) $display("[TB] FAIL mis_fault: got fault=%b pc=%h v=%b expected fault=1 pc=6 v=0", bus.fault, bus.faultPc, bus.instValid); else passCount++;
    tick();
  endtask

  task automatic test_reset_midstream();
    bus.redirect = 1'b1; bus.redirectPc = 64'h10;
    tick();
    bus.redirect = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    checkCount++; if (bus.instValid !== 1'b1 || bus.instPc !== 64'h10) $display("[TB] FAIL mid_prerst: got v=%b pc=%h expected v=1 pc=10", bus.instValid, bus.instPc); else passCount++;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkCount++;
    if (bus.instValid !== 1'b0 || bus.inst !== 32'h0 || bus.instPc !== 64'h0 || bus.imReq !== 1'b0 || bus.fault !== 1'b0 || bus.faultPc !== 64'h0 || bus.imAddr !== 64'h0)
      $display("[TB] FAIL mid_reset: got v=%b inst=%h pc=%h req=%b fault=%b fpc=%h addr=%h expected all zero", bus.instValid, bus.inst, bus.instPc, bus.imReq, bus.fault, bus.faultPc, bus.imAddr);
    else passCount++;
    tick();
  endtask

  task automatic test_back_to_back();
    bus.redirect = 1'b1; bus.redirectPc = 64'h10;
    tick();
    bus.redirect = 1'b0; en = 1'b1;
    @(negedge clk);
    checkCount++; if (bus.imReq !== 1'b0 || bus.imAddr !== 64'h10 || bus.instValid !== 1'b0) $display("[TB] FAIL idle_redir: got req=%b addr=%h v=%b expected req=0 addr=10 v=0", bus.imReq, bus.imAddr, bus.instValid); else passCount++;
    tick();
    en = 1'b0;
    @(negedge clk);
    checkCount++; if (bus.imReq !== 1'b1 || bus.imAddr !== 64'h10) $display("[TB] FAIL idle_start: got req=%b addr=%h expected req=1 addr=10", bus.imReq, bus.imAddr); else passCount++;
    tick();
    bus.redirect = 1'b1; bus.redirectPc = 64'h30;
    @(negedge clk);
    checkCount++; if (bus.instValid !== 1'b1 || bus.instPc !== 64'h10) $display("[TB] FAIL b2b_head: got v=%b pc=%h expected v=1 pc=10", bus.instValid, bus.instPc); else passCount++;
    tick();
    bus.redirectPc = 64'h08;
    @(negedge clk);
    checkCount++; if (bus.instValid !== 1'b0 || bus.imReq !== 1'b0) $display("[TB] FAIL b2b_second: got v=%b req=%b expected v=0 req=0", bus.instValid, bus.imReq); else passCount++;
    tick();
    bus.redirect = 1'b0;
    @(negedge clk);
    checkCount++; if (bus.instValid !== 1'b0 || bus.imReq !== 1'b1 || bus.imAddr !== 64'h08) $display("[TB] FAIL b2b_fetch: got v=%b req=%b addr=%h expected v=0 req=1 addr=8", bus.instValid, bus.imReq, bus.imAddr); else passCount++;
    tick();
    @(negedge clk);
    checkCount++; if (bus.instValid !== 1'b1 || bus.instPc !== 64'h08 || bus.inst !== expInst(64'h08)) $display("[TB] FAIL b2b_last_wins: got v=%b pc=%h inst=%h expected v=1 pc=8 inst=%h", bus.instValid, bus.instPc, bus.inst, expInst(64'h08)); else passCount++;
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_range_fault();
    test_misaligned();
    test_reset_midstream();
    test_back_to_back();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
